complex_acc: RTL and testbench

COMPLEX_ACC -- requirements
Module: complex_acc

---
 rtl/complex_pkg.sv | 14 +
 rtl/complex_acc_if.sv | 29 ++
 rtl/complex_acc_sat_add.sv | 24 ++
 rtl/complex_acc.sv | 112 +++++++++++
 tb/tb_complex_acc.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/complex_pkg.sv
// Shared defaults and FSM state type for the complex frame accumulator.
package complex_pkg;

  localparam int IN_W_DEF  = 16;
  localparam int ACC_W_DEF = 24;
  localparam int LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/complex_acc_if.sv
// Streaming bus of the complex accumulator: product samples in, frame sums out.
interface complex_acc_if #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_real;
  logic signed [IN_W-1:0]  in_imag;
  logic [LEN_W-1:0]        len;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_real;
  logic signed [ACC_W-1:0] out_imag;
  logic                    out_ovf;

  modport slave (
    input  in_valid, in_real, in_imag, len, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_ovf
  );

  modport master (
    output in_valid, in_real, in_imag, len, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_ovf
  );

endinterface

// File: rtl/complex_acc_sat_add.sv
// Signed saturating adder; clamps to the W-bit range and flags any clamp.
module sat_add #(
  parameter int W = 24
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] sum_o,
  output logic                ovf_o
);

  logic [W:0] full;

  // One guard bit: overflow shows up as disagreement between the top two bits.
  assign full = {a_i[W-1], a_i} + {b_i[W-1], b_i};

  always_comb begin
    ovf_o = full[W] ^ full[W-1];
    sum_o = full[W-1:0];
    if (ovf_o) begin
      sum_o = full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/complex_acc.sv
// Accumulates a frame of complex products with per-component saturation,
// then holds the sum until the downstream consumer takes it.
module complex_acc
  import complex_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  complex_acc_if.slave  bus
);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_re_q, acc_re_d;
  logic signed [ACC_W-1:0] acc_im_q, acc_im_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic                    ovf_q, ovf_d;

  logic signed [ACC_W-1:0] smp_re, smp_im, sum_re, sum_im;
  logic                    ovf_re, ovf_im;
  logic [LEN_W-1:0]        cnt_inc;
  logic                    in_fire, out_fire;

  assign smp_re  = ACC_W'(bus.in_real);
  assign smp_im  = ACC_W'(bus.in_imag);
  assign cnt_inc = cnt_q + 1'b1;

  sat_add #(.W(ACC_W)) u_sat_re (
    .a_i   (acc_re_q),
    .b_i   (smp_re),
    .sum_o (sum_re),
    .ovf_o (ovf_re)
  );

  sat_add #(.W(ACC_W)) u_sat_im (
    .a_i   (acc_im_q),
    .b_i   (smp_im),
    .sum_o (sum_im),
    .ovf_o (ovf_im)
  );

  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_real  = acc_re_q;
  assign bus.out_imag  = acc_im_q;
  assign bus.out_ovf   = ovf_q;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d  = state_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          // A zero length would never close the frame, so it counts as one.
          len_d    = (bus.len == '0) ? LEN_W'(1) : bus.len;
          acc_re_d = smp_re;
          acc_im_d = smp_im;
          cnt_d    = LEN_W'(1);
          ovf_d    = 1'b0;
          state_d  = (len_d == LEN_W'(1)) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (in_fire) begin
          acc_re_d = sum_re;
          acc_im_d = sum_im;
          cnt_d    = cnt_inc;
          ovf_d    = ovf_q | ovf_re | ovf_im;
          if (cnt_inc == len_q) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_fire) begin
          state_d = IDLE;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_re_q <= '0;
      acc_im_q <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_complex_acc.sv
// Directed bench for complex_acc: default-width instance plus a 16-bit
// accumulator instance used to drive saturation.
module tb_complex_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  complex_acc_if #(.IN_W(16), .ACC_W(24), .LEN_W(8)) ifa ();
  complex_acc_if #(.IN_W(16), .ACC_W(16), .LEN_W(8)) ifb ();

  complex_acc #(.IN_W(16), .ACC_W(24), .LEN_W(8)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  complex_acc #(.IN_W(16), .ACC_W(16), .LEN_W(8)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int re, input int im);
    int n = 0;
    ifa.in_valid = 1'b1;
    ifa.in_real  = 16'(re);
    ifa.in_imag  = 16'(im);
    while (!ifa.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!ifa.in_ready) begin
      total++;
      bad++;
      $error("FAIL send_a_timeout: in_ready observed=0 expected=1");
    end
    tick();
    ifa.in_valid = 1'b0;
  endtask

  task automatic send_b(input int re, input int im);
    int n = 0;
    ifb.in_valid = 1'b1;
    ifb.in_real  = 16'(re);
    ifb.in_imag  = 16'(im);
    while (!ifb.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!ifb.in_ready) begin
      total++;
      bad++;
      $error("FAIL send_b_timeout: in_ready observed=0 expected=1");
    end
    tick();
    ifb.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    logic rdy;

    ifa.in_valid = 1'b0; ifa.in_real = '0; ifa.in_imag = '0;
    ifa.len = 8'd0;      ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_real = '0; ifb.in_imag = '0;
    ifb.len = 8'd0;      ifb.out_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", int'(ifa.in_ready), 1);
    check("rst_out_valid", int'(ifa.out_valid), 0);
    check("rst_out_real", int'(ifa.out_real), 0);
    check("rst_out_imag", int'(ifa.out_imag), 0);
    check("rst_out_ovf", int'(ifa.out_ovf), 0);

    // Four-sample frame, output one cycle after the last transfer
    ifa.len = 8'd4;
    send_a(1, 2);
    send_a(3, -4);
    send_a(5, 6);
    check("f4_not_done", int'(ifa.out_valid), 0);
    send_a(-7, 8);
    check("f4_out_valid", int'(ifa.out_valid), 1);
    check("f4_in_ready", int'(ifa.in_ready), 0);
    check("f4_out_real", int'(ifa.out_real), 2);
    check("f4_out_imag", int'(ifa.out_imag), 12);
    check("f4_out_ovf", int'(ifa.out_ovf), 0);
    tick();
    check("f4_released", int'(ifa.out_valid), 0);
    $display("frame len=4 -> (%0d,%0d)", ifa.out_real, ifa.out_imag);

    // len=0 acts as 1; held output under backpressure
    ifa.len = 8'd0;
    ifa.out_ready = 1'b0;
    send_a(-100, 50);
    check("l0_out_valid", int'(ifa.out_valid), 1);
    check("l0_out_real", int'(ifa.out_real), -100);
    check("l0_out_imag", int'(ifa.out_imag), 50);
    ifa.in_valid = 1'b1; ifa.in_real = 16'(7); ifa.in_imag = 16'(7);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("l0_hold_in_ready", int'(ifa.in_ready), 0);
      check("l0_hold_valid", int'(ifa.out_valid), 1);
      check("l0_hold_real", int'(ifa.out_real), -100);
      check("l0_hold_imag", int'(ifa.out_imag), 50);
    end
    ifa.out_ready = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    check("l0_released", int'(ifa.out_valid), 0);
    check("l0_no_accept_on_out", int'(ifa.out_real), -100);
    tick();
    check("l0_idle_still", int'(ifa.out_real), -100);
    $display("frame len=0 -> (-100,50) held 5 cycles");

    // Gapped samples, len changed mid-frame
    ifa.len = 8'd3;
    send_a(10, 20);
    ifa.len = 8'd1;
    tick(); tick();
    send_a(30, -5);
    check("gap_not_done", int'(ifa.out_valid), 0);
    tick(); tick();
    send_a(-1, 1);
    check("gap_out_valid", int'(ifa.out_valid), 1);
    check("gap_out_real", int'(ifa.out_real), 39);
    check("gap_out_imag", int'(ifa.out_imag), 16);
    tick();
    $display("frame len=3 gapped -> (39,16)");

    // Reset mid-frame discards partial frame
    ifa.len = 8'd4;
    send_a(100, 200);
    send_a(100, 200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_in_ready", int'(ifa.in_ready), 1);
    check("mid_rst_real", int'(ifa.out_real), 0);
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_no_valid", int'(ifa.out_valid), 0);
      tick();
    end
    ifa.len = 8'd1;
    send_a(9, 9);
    check("post_rst_valid", int'(ifa.out_valid), 1);
    check("post_rst_real", int'(ifa.out_real), 9);
    check("post_rst_imag", int'(ifa.out_imag), 9);
    tick();
    $display("reset mid-frame, next frame -> (9,9)");

    // Back-to-back frames, one bubble per frame
    ifa.len = 8'd2;
    ifa.out_ready = 1'b1;
    idx = 1;
    ifa.in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      ifa.in_real = 16'(idx);
      ifa.in_imag = 16'(-idx);
      check("b2b_in_ready", int'(ifa.in_ready), (c % 3 != 2) ? 1 : 0);
      if (c % 3 == 2) begin
        check("b2b_out_valid", int'(ifa.out_valid), 1);
        check("b2b_out_real", int'(ifa.out_real), 4 * (c / 3) + 3);
        check("b2b_out_imag", int'(ifa.out_imag), -(4 * (c / 3) + 3));
        $display("b2b frame %0d -> (%0d,%0d)", c / 3, ifa.out_real, ifa.out_imag);
      end else begin
        check("b2b_out_idle", int'(ifa.out_valid), 0);
      end
      rdy = ifa.in_ready;
      tick();
      if (rdy) idx++;
    end
    ifa.in_valid = 1'b0;
    check("b2b_consumed", idx, 9);

    // Saturation on the 16-bit accumulator instance
    ifb.len = 8'd2;
    for (int f = 0; f < 300; f++) begin
      send_b(32767, -32768);
      send_b(32767, -32768);
      check("sat_valid", int'(ifb.out_valid), 1);
      check("sat_real", int'(ifb.out_real), 32767);
      check("sat_imag", int'(ifb.out_imag), -32768);
      check("sat_ovf", int'(ifb.out_ovf), 1);
    end
    tick();
    check("sat_ovf_cleared", int'(ifb.out_ovf), 0);
    $display("saturation 300 frames -> (32767,-32768) ovf=1");
    send_b(1, 2);
    send_b(3, 4);
    check("clean_real", int'(ifb.out_real), 4);
    check("clean_imag", int'(ifb.out_imag), 6);
    check("clean_ovf", int'(ifb.out_ovf), 0);
    tick();
    $display("clean frame -> (4,6) ovf=0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
